// File: rtl/fft_pkg.sv
// Shared types for the FFT accelerator and its butterfly sequencer.
package fft_pkg;

  // Accelerator operator codes; the encoding is shared with the datapath.
  typedef enum logic [4:0] {
    BFLY_DIT_C = 5'b00000,
    BFLY_DIT_D = 5'b00001,
    BFLY_DIF_C = 5'b00010,
    BFLY_DIF_D = 5'b00011,
    FAST_ABS   = 5'b00100
  } fft_op_e;

  // Sequencer states: two reads, one latch, two writes per butterfly.
  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StLatch,
    StWrC,
    StWrD,
    StDone,
    StErr
  } fft_seq_state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address generator: maps (k, s) to the operand pair (a, b) and twiddle index t.
module fft_addr_gen #(
  parameter int unsigned LOG2_N = 8
) (
  input  logic [LOG2_N-2:0] k,
  input  logic [3:0]        s,
  input  logic [3:0]        n_log2,
  input  logic              dif,
  output logic [LOG2_N-1:0] a,
  output logic [LOG2_N-1:0] b,
  output logic [LOG2_N-2:0] t
);

  localparam int unsigned KW = LOG2_N - 1;
  localparam logic [LOG2_N-1:0] One = {{(LOG2_N-1){1'b0}}, 1'b1};

  logic [3:0]        p;
  logic [KW-1:0]     j_mask;
  logic [KW-1:0]     j;
  logic [LOG2_N-1:0] h;

  // p = log2 of the half-span; DIF walks the spans from widest to narrowest.
  always_comb begin
    p      = dif ? (n_log2 - 4'd1 - s) : s;
    h      = One << p;
    j_mask = ~({KW{1'b1}} << p);
    j      = k & j_mask;
    // Insert a zero at bit p of k to get the lower operand; b sets that bit.
    a      = (({1'b0, k} >> p) << (p + 4'd1)) | {1'b0, j};
    b      = a | h;
    t      = j << (n_log2 - 4'd1 - p);
  end

endmodule

// File: rtl/fft_sequencer.sv
// In-place radix-2 FFT controller: one butterfly every five cycles through
// the external combinational accelerator, operands and results in a single-port RAM.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2_N = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        n_log2_i,
  input  logic              dif_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LOG2_N-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [LOG2_N-2:0] tw_addr_o,
  input  logic [31:0]       tw_rdata_i,
  output logic [4:0]        fft_op_o,
  output logic [31:0]       fft_a_o,
  output logic [31:0]       fft_b_o,
  output logic [31:0]       fft_c_o,
  input  logic [31:0]       fft_result_i
);

  localparam int unsigned KW = LOG2_N - 1;

  fft_seq_state_e state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [3:0]     s_q, s_d;
  logic [3:0]     n_log2_q, n_log2_d;
  logic           dif_q, dif_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [31:0]    w_q, w_d;

  logic [LOG2_N-1:0] addr_a;
  logic [LOG2_N-1:0] addr_b;
  logic [KW-1:0]     tw_idx;
  logic [KW-1:0]     k_max;
  logic              last_k;
  logic              last_s;
  logic              size_ok;
  fft_op_e           op;

  fft_addr_gen #(
    .LOG2_N(LOG2_N)
  ) u_addr_gen (
    .k      (k_q),
    .s      (s_q),
    .n_log2 (n_log2_q),
    .dif    (dif_q),
    .a      (addr_a),
    .b      (addr_b),
    .t      (tw_idx)
  );

  // Loop bounds for the current transform and start-time size validation.
  always_comb begin
    k_max   = {KW{1'b1}} >> (4'(LOG2_N) - n_log2_q);
    last_k  = (k_q == k_max);
    last_s  = (s_q == n_log2_q - 4'd1);
    size_ok = (n_log2_i != 4'd0) && (32'(n_log2_i) <= LOG2_N);
  end

  // State register and operand/config capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      k_q      <= '0;
      s_q      <= '0;
      n_log2_q <= '0;
      dif_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      w_q      <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      s_q      <= s_d;
      n_log2_q <= n_log2_d;
      dif_q    <= dif_d;
      a_q      <= a_d;
      b_q      <= b_d;
      w_q      <= w_d;
    end
  end

  // Next-state, counter advance and memory/accelerator drive.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    s_d         = s_q;
    n_log2_d    = n_log2_q;
    dif_d       = dif_q;
    a_d         = a_q;
    b_d         = b_q;
    w_d         = w_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    tw_addr_o   = '0;
    op          = BFLY_DIT_C;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (size_ok) begin
            state_d  = StRdA;
            n_log2_d = n_log2_i;
            dif_d    = dif_i;
            k_d      = '0;
            s_d      = '0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StRdA: begin
        busy_o     = 1'b1;
        mem_addr_o = addr_a;
        tw_addr_o  = tw_idx;
        state_d    = StRdB;
      end
      StRdB: begin
        busy_o     = 1'b1;
        mem_addr_o = addr_b;
        a_d        = mem_rdata_i;
        w_d        = tw_rdata_i;
        state_d    = StLatch;
      end
      StLatch: begin
        busy_o     = 1'b1;
        mem_addr_o = addr_b;
        b_d        = mem_rdata_i;
        state_d    = StWrC;
      end
      StWrC: begin
        busy_o      = 1'b1;
        mem_addr_o  = addr_a;
        mem_we_o    = 1'b1;
        mem_wdata_o = fft_result_i;
        op          = dif_q ? BFLY_DIF_C : BFLY_DIT_C;
        state_d     = StWrD;
      end
      StWrD: begin
        busy_o      = 1'b1;
        mem_addr_o  = addr_b;
        mem_we_o    = 1'b1;
        mem_wdata_o = fft_result_i;
        op          = dif_q ? BFLY_DIF_D : BFLY_DIT_D;
        state_d     = StRdA;
        if (last_k) begin
          k_d = '0;
          if (last_s) begin
            state_d = StDone;
          end else begin
            s_d = s_q + 4'd1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        done_o  = 1'b1;
        err_o   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign fft_op_o = op;
  assign fft_a_o  = a_q;
  assign fft_b_o  = b_q;
  assign fft_c_o  = w_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: RAM, twiddle ROM and accelerator models,
// with a loop-based reference FFT schedule and randomized data and sizes.
module tb_fft_sequencer;
  import fft_pkg::*;

  localparam int unsigned LOG2_N = 8;
  localparam int unsigned NMAX   = 1 << LOG2_N;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [3:0]        n_log2_i;
  logic              dif_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [LOG2_N-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata;
  logic [LOG2_N-2:0] tw_addr_o;
  logic [31:0]       tw_rdata;
  logic [4:0]        fft_op_o;
  logic [31:0]       fft_a_o;
  logic [31:0]       fft_b_o;
  logic [31:0]       fft_c_o;
  logic [31:0]       fft_result;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  logic [31:0] ram      [NMAX];
  logic [31:0] init_mem [NMAX];
  logic [31:0] ref_mem  [NMAX];
  logic [31:0] tw_rom   [NMAX/2];
  logic        load_req;

  fft_sequencer #(
    .LOG2_N(LOG2_N)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_i),
    .n_log2_i     (n_log2_i),
    .dif_i        (dif_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata),
    .tw_addr_o    (tw_addr_o),
    .tw_rdata_i   (tw_rdata),
    .fft_op_o     (fft_op_o),
    .fft_a_o      (fft_a_o),
    .fft_b_o      (fft_b_o),
    .fft_c_o      (fft_c_o),
    .fft_result_i (fft_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM and twiddle ROM with one-cycle read latency.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NMAX; i++) ram[i] <= init_mem[i];
    end else if (mem_we_o) begin
      ram[mem_addr_o] <= mem_wdata_o;
    end
    mem_rdata <= ram[mem_addr_o];
    tw_rdata  <= tw_rom[tw_addr_o];
    if (mem_we_o) wr_count <= wr_count + 1;
  end

  function automatic logic [31:0] cadd(logic [31:0] x, logic [31:0] y);
    return {x[31:16] + y[31:16], x[15:0] + y[15:0]};
  endfunction

  function automatic logic [31:0] csub(logic [31:0] x, logic [31:0] y);
    return {x[31:16] - y[31:16], x[15:0] - y[15:0]};
  endfunction

  // Q1.15 complex multiply, wrapping to 16 bits.
  function automatic logic [31:0] cmul(logic [31:0] x, logic [31:0] y);
    longint xr, xi, yr, yi, re, im;
    xr = longint'($signed(x[15:0]));
    xi = longint'($signed(x[31:16]));
    yr = longint'($signed(y[15:0]));
    yi = longint'($signed(y[31:16]));
    re = (xr * yr - xi * yi) >>> 15;
    im = (xr * yi + xi * yr) >>> 15;
    return {im[15:0], re[15:0]};
  endfunction

  function automatic logic [31:0] accel(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                        logic [31:0] c);
    case (op)
      5'd0:    return cadd(a, cmul(c, b));
      5'd1:    return csub(a, cmul(c, b));
      5'd2:    return cadd(a, b);
      5'd3:    return cmul(csub(a, b), c);
      default: return 32'd0;
    endcase
  endfunction

  always_comb fft_result = accel(fft_op_o, fft_a_o, fft_b_o, fft_c_o);

  task automatic test_reset();
    logic [151:0] obs;
    rst = 1'b1;
    @(negedge clk);
    obs = {busy_o, done_o, err_o, mem_we_o, mem_addr_o, tw_addr_o, fft_op_o, mem_wdata_o,
           fft_a_o, fft_b_o, fft_c_o};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, mem_we_o} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0000", {busy_o, done_o, err_o, mem_we_o});
    end
  endtask

  // Runs one transform with cycle-by-cycle schedule checks and a final RAM compare.
  // glitch_at > 0 pulses start with a different size at that cycle offset.
  task automatic run_fft(input int n, input bit dif, input int glitch_at, input string name);
    int qa[$], qb[$], qt[$];
    int nn, half, h, nb, w0, i, ph, bad, first_bad;
    logic [31:0] ra, rb, rw, rc, rd;
    logic [151:0] obs, expv, mask;
    logic m_addr, m_tw, m_wd, m_opnd;
    logic [3:0] ctl;
    logic [LOG2_N-1:0] e_addr;
    logic [LOG2_N-2:0] e_tw;
    logic [4:0] e_op;
    logic [31:0] e_wd;
    nn   = 1 << n;
    half = nn / 2;
    for (int x = 0; x < NMAX; x++) begin
      init_mem[x] = $urandom;
      ref_mem[x]  = init_mem[x];
    end
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    for (int s = 0; s < n; s++) begin
      h = dif ? (nn >> (s + 1)) : (1 << s);
      for (int g = 0; g < nn; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          qa.push_back(g + j);
          qb.push_back(g + j + h);
          qt.push_back(j * (half / h));
        end
      end
    end
    nb = qa.size();
    w0 = wr_count;
    start_i  = 1'b1;
    n_log2_i = 4'(n);
    dif_i    = dif;
    for (int d = 1; d <= 5 * nb + 2; d++) begin
      @(negedge clk);
      if (d == 1) begin
        start_i  = 1'b0;
        n_log2_i = 4'($urandom);
        dif_i    = ~dif;
      end
      m_addr = 1'b0; m_tw = 1'b0; m_wd = 1'b0; m_opnd = 1'b0;
      e_addr = '0; e_tw = '0; e_op = '0; e_wd = '0;
      if (d <= 5 * nb) begin
        i   = (d - 1) / 5;
        ph  = (d - 1) % 5;
        ctl = (ph >= 3) ? 4'b1001 : 4'b1000;
        if (ph == 0) begin
          m_addr = 1'b1; e_addr = LOG2_N'(qa[i]);
          m_tw = 1'b1; e_tw = (LOG2_N-1)'(qt[i]);
        end else if (ph == 1) begin
          m_addr = 1'b1; e_addr = LOG2_N'(qb[i]);
        end else if (ph == 3) begin
          ra = ref_mem[qa[i]];
          rb = ref_mem[qb[i]];
          rw = tw_rom[qt[i]];
          rc = accel(dif ? 5'd2 : 5'd0, ra, rb, rw);
          rd = accel(dif ? 5'd3 : 5'd1, ra, rb, rw);
          m_addr = 1'b1; e_addr = LOG2_N'(qa[i]);
          m_wd = 1'b1; e_wd = rc; m_opnd = 1'b1;
          e_op = dif ? 5'd2 : 5'd0;
        end else if (ph == 4) begin
          m_addr = 1'b1; e_addr = LOG2_N'(qb[i]);
          m_wd = 1'b1; e_wd = rd; m_opnd = 1'b1;
          e_op = dif ? 5'd3 : 5'd1;
          ref_mem[qa[i]] = rc;
          ref_mem[qb[i]] = rd;
        end
      end else if (d == 5 * nb + 1) begin
        ctl = 4'b0100;
      end else begin
        ctl = 4'b0000;
      end
      obs  = {busy_o, done_o, err_o, mem_we_o, mem_addr_o, tw_addr_o, fft_op_o, mem_wdata_o,
              fft_a_o, fft_b_o, fft_c_o};
      expv = {ctl, e_addr, e_tw, e_op, e_wd, ra, rb, rw};
      mask = {4'hF, {LOG2_N{m_addr}}, {(LOG2_N-1){m_tw}}, 5'h1F, {32{m_wd}}, {96{m_opnd}}};
      checks++;
      if ((obs & mask) !== (expv & mask)) begin
        failures++;
        $display("FAIL %s sched d=%0d got=%h exp=%h", name, d, obs & mask, expv & mask);
      end
      if (glitch_at > 0 && d == glitch_at) begin
        start_i  = 1'b1;
        n_log2_i = (n == LOG2_N) ? 4'd1 : 4'(n + 1);
        dif_i    = ~dif;
      end else if (glitch_at > 0 && d == glitch_at + 1) begin
        start_i = 1'b0;
      end
    end
    checks++;
    if (wr_count - w0 !== 2 * nb) begin
      failures++;
      $display("FAIL %s writes got=%0d exp=%0d", name, wr_count - w0, 2 * nb);
    end
    bad = 0;
    first_bad = -1;
    for (int x = 0; x < NMAX; x++) begin
      if (ram[x] !== ref_mem[x]) begin
        bad++;
        if (first_bad < 0) first_bad = x;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s ram_contents bad_words=%0d first=%0d got=%h exp=%h", name, bad,
               first_bad, ram[first_bad], ref_mem[first_bad]);
    end
  endtask

  task automatic test_invalid(input int n);
    int w0;
    logic [4:0] got, expv;
    w0 = wr_count;
    start_i  = 1'b1;
    n_log2_i = 4'(n);
    dif_i    = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk);
      if (d == 1) start_i = 1'b0;
      got  = {busy_o, done_o, err_o, mem_we_o, |fft_op_o};
      expv = (d == 1) ? 5'b01100 : 5'b00000;
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL invalid_n%0d d=%0d got=%b exp=%b", n, d, got, expv);
      end
    end
    checks++;
    if (wr_count != w0) begin
      failures++;
      $display("FAIL invalid_n%0d writes got=%0d exp=0", n, wr_count - w0);
    end
  endtask

  task automatic test_reset_midway();
    @(negedge clk);
    start_i  = 1'b1;
    n_log2_i = 4'd2;
    dif_i    = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      if (d == 1) start_i = 1'b0;
    end
    checks++;
    if ({busy_o, mem_we_o, fft_op_o} !== {2'b11, 5'd0}) begin
      failures++;
      $display("FAIL pre_reset_wrc got=%b exp=1100000", {busy_o, mem_we_o, fft_op_o});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, mem_we_o, done_o, fft_a_o, fft_b_o, fft_c_o} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b%b%b a=%h b=%h c=%h exp=0", busy_o, mem_we_o, done_o,
               fft_a_o, fft_b_o, fft_c_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_fft(1, 1'b0, 0, "after_reset");
  endtask

  initial begin
    rst      = 1'b1;
    start_i  = 1'b0;
    n_log2_i = 4'd0;
    dif_i    = 1'b0;
    load_req = 1'b0;
    for (int x = 0; x < NMAX / 2; x++) tw_rom[x] = $urandom;
    test_reset();
    run_fft(1, 1'b0, 0, "n1_dit");
    run_fft(2, 1'b0, 0, "n2_dit");
    run_fft(2, 1'b1, 0, "n2_dif");
    test_invalid(0);
    test_invalid(LOG2_N + 1);
    test_invalid(15);
    run_fft(3, 1'b0, 7, "start_ignored");
    run_fft(3, 1'b1, 33, "start_ignored_dif");
    test_reset_midway();
    repeat (4) begin
      run_fft(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 0, "random");
    end
    run_fft(LOG2_N, 1'b0, 0, "nmax_dit");
    run_fft(LOG2_N, 1'b1, 0, "nmax_dif");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Controller that runs a complete in-place radix-2 FFT of N = 2^n_log2 complex points held in a single-port data RAM, one butterfly at a time, through the combinational FFT accelerator. It generates data and twiddle addresses, fetches operands, drives the accelerator operator/operands, and writes both butterfly outputs back. It sits beside the core as a memory-mapped DMA-style engine: software loads the RAM, pulses start, and waits for done.

## Interface
- LOG2_N, default 8: maximum supported transform size (N_max = 2^LOG2_N); RAM depth N_max, twiddle ROM depth N_max/2.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle request; accepted only in IDLE.
- n_log2_i  in  4  transform size exponent, sampled on accepted start.
- dif_i  in  1  0 = DIT (bit-reversed input, natural output), 1 = DIF (natural input, bit-reversed output); sampled on start.
- busy_o  out  1  high from the cycle after accepted start until done.
- done_o  out  1  one-cycle pulse at completion.
- err_o  out  1  one-cycle pulse with done_o when n_log2 is invalid.
- mem_addr_o  out  LOG2_N  data RAM address.
- mem_we_o  out  1  RAM write enable.
- mem_wdata_o  out  32  write data {im[31:16], re[15:0]}.
- mem_rdata_i  in  32  read data, valid one cycle after address.
- tw_addr_o  out  LOG2_N-1  twiddle ROM index.
- tw_rdata_i  in  32  twiddle {im, re}, valid one cycle after address.
- fft_op_o  out  5  accelerator operator.
- fft_a_o, fft_b_o, fft_c_o  out  32 each  accelerator operands a, b, coeff.
- fft_result_i  in  32  accelerator result (combinational).

## Operation
- Valid n_log2: 1..LOG2_N. Otherwise start -> ERR state for one cycle: done_o=err_o=1, no RAM access.
- Butterfly index k counts 0..N/2-1 per stage; stage s counts 0..n_log2-1. Width of half-span h: DIT h = 2^s; DIF h = 2^(n_log2-1-s).
- With p = log2(h): j = k & (h-1); a = ((k >> p) << (p+1)) | j; b = a + h; twiddle index t = j << (n_log2-1-p).
- FSM states: IDLE, RD_A, RD_B, LATCH, WR_C, WR_D, DONE, ERR.
  - RD_A: mem_addr=a, tw_addr=t.
  - RD_B: mem_addr=b; capture mem_rdata -> a_q, tw_rdata -> w_q.
  - LATCH: capture mem_rdata -> b_q.
  - WR_C: fft_op = 0 (DIT c) / 2 (DIF c); mem_addr=a, we=1, wdata=fft_result_i.
  - WR_D: fft_op = 1 / 3; mem_addr=b, we=1, wdata=fft_result_i. Then advance k/s: if last k of last stage -> DONE, else RD_A.
  - DONE/ERR: one cycle, -> IDLE.
- fft_a_o=a_q, fft_b_o=b_q, fft_c_o=w_q at all times; fft_op_o=0 outside WR_C/WR_D.
- start_i while busy is ignored; config registers unchanged.
- Reset (any state): all registers cleared, state IDLE. RAM contents are then undefined; no partial-transform recovery.

## Timing
- Reset values: busy_o=0, done_o=0, err_o=0, mem_we_o=0, mem_addr_o=0, tw_addr_o=0, fft_op_o=0, operand outputs 0, mem_wdata_o=0.
- Start accepted at cycle T -> RD_A at T+1; busy_o high T+1 through last WR_D.
- 5 cycles per butterfly; B = (N/2)*n_log2 butterflies; done_o at T+5B+1, busy_o low that cycle.
- Invalid size: done_o/err_o at T+1, busy_o never asserted.
- mem_we_o high only in WR_C/WR_D; exactly 2B writes per transform.

## Structure
- fft_pkg: fft_op_e enum (BFLY_DIT_C=5'b00000, BFLY_DIT_D=5'b00001, BFLY_DIF_C=5'b00010, BFLY_DIF_D=5'b00011, FAST_ABS=5'b00100) shared with the accelerator; fft_seq_state_e enum.
- Sub-module fft_addr_gen: combinational (k, s, n_log2, dif) -> (a, b, t); FSM and counters stay in fft_sequencer.

## Test plan
- n_log2=1, DIT, start at T -> reads addr 0 then 1, writes addr 0 op 0 at T+4, addr 1 op 1 at T+5, done_o at T+6, tw_addr 0.
- n_log2=2, DIT -> pairs/twiddles (0,1,t0),(2,3,t0),(0,2,t0),(1,3,t1); done_o at T+21; RAM matches reference model of the accelerator.
- n_log2=2, DIF -> pairs (0,2,t0),(1,3,t1),(0,1,t0),(2,3,t0); ops 2/3.
- n_log2=0 and n_log2=LOG2_N+1 -> done_o=err_o=1 at T+1, zero writes, busy_o stays 0.
- start_i pulsed mid-transform with different n_log2 -> ignored, original schedule and done time unchanged.
- rst_i asserted during WR_C -> mem_we_o, busy_o drop immediately; after release, new start with n_log2=1 completes in 6 cycles.
